// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM unified memory bus arbiter with MEM priority (optional ARB_TIMEOUT_EN bus-ready timeout)
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  input  logic          i_if_kill,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_ack,
  input  logic          i_mem_req,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_wdata,
  output logic [DW-1:0] o_mem_rdata,
  output logic          o_mem_ack,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_addr,
  output logic [DW-1:0] o_bus_wdata,
  input  logic [DW-1:0] i_bus_rdata,
  input  logic          i_bus_ready,
  output logic          o_bus_err,
  output logic          o_stall_if,
  output logic          o_stall_mem
);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, RESP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          owner_mem_q, owner_mem_d;
  logic          kill_q, kill_d;
  logic          bus_req_q, bus_req_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = (MAX_WAIT == 0);
`endif

  // Grant, bus wait and response sequencing plus request latching
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    owner_mem_d = owner_mem_q;
    kill_d      = kill_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    to_d        = to_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = '0;
        to_d  = 1'b0;
`endif
        if (i_mem_req) begin
          owner_mem_d = 1'b1;
          addr_d      = i_mem_addr;
          we_d        = i_mem_we;
          wdata_d     = i_mem_wdata;
          kill_d      = 1'b0;
          state_d     = BUS_MEM;
        end else if (i_if_req) begin
          owner_mem_d = 1'b0;
          addr_d      = i_if_addr;
          we_d        = 1'b0;
          wdata_d     = '0;
          // the grant cycle already counts as part of the fetch's lifetime
          kill_d      = i_if_kill;
          state_d     = BUS_IF;
        end
      end
      BUS_IF, BUS_MEM: begin
        if (state_q == BUS_IF && i_if_kill) kill_d = 1'b1;
        if (i_bus_ready) begin
          if (state_q == BUS_MEM) begin
            if (!we_q) mem_rdata_d = i_bus_rdata;
          end else begin
            if_rdata_d = i_bus_rdata;
          end
          state_d = RESP;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(MAX_WAIT - 1)) begin
          // this cycle is the MAX_WAIT-th without ready: abandon the access
          to_d    = 1'b1;
          state_d = RESP;
          if (state_q == BUS_MEM) mem_rdata_d = '0;
          else                    if_rdata_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bus_req_d = (state_d == BUS_IF) || (state_d == BUS_MEM);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      owner_mem_q <= 1'b0;
      kill_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
      to_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      owner_mem_q <= owner_mem_d;
      kill_q      <= kill_d;
      bus_req_q   <= bus_req_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      to_q        <= to_d;
`endif
    end
  end

  // Acks pulse in RESP; a kill seen at any point of the fetch suppresses its ack
  always_comb begin
    o_if_ack    = (state_q == RESP) && !owner_mem_q && !kill_q && !i_if_kill;
    o_mem_ack   = (state_q == RESP) && owner_mem_q;
    o_stall_if  = i_if_req && !o_if_ack;
    o_stall_mem = i_mem_req && !o_mem_ack;
  end

  assign o_bus_req   = bus_req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_mem_rdata = mem_rdata_q;
`ifdef ARB_TIMEOUT_EN
  assign o_bus_err   = (state_q == RESP) && to_q;
`else
  assign o_bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_kill = 1'b0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ready = 1'b0;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;

  typedef struct packed {
    logic        is_mem;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_kill(if_kill),
    .o_if_rdata(if_rdata), .o_if_ack(if_ack),
    .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
    .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata), .o_mem_ack(mem_ack),
    .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata), .i_bus_ready(bus_ready),
    .o_bus_err(bus_err), .o_stall_if(stall_if), .o_stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; any ack pops the scoreboard and is checked against it
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (if_ack === 1'b1 || mem_ack === 1'b1) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_ack: observed if_ack=%b mem_ack=%b expected none", if_ack, mem_ack);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_owner_mem", {31'd0, mem_ack}, {31'd0, e.is_mem});
        chk("ack_owner_if", {31'd0, if_ack}, {31'd0, ~e.is_mem});
        chk("ack_rdata", e.is_mem ? mem_rdata : if_rdata, e.data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step();
    step();
    chk("rst_bus_req", {31'd0, bus_req}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_if_ack", {31'd0, if_ack}, 0);
    chk("rst_mem_ack", {31'd0, mem_ack}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_bus_err", {31'd0, bus_err}, 0);
    rst_n = 1'b1;
    step();

    // single fetch, ready in the first bus cycle
    if_req = 1'b1; if_addr = 32'h100;
    #1 chk("f_stall_c0", {31'd0, stall_if}, 1);
    chk("f_bus_req_c0", {31'd0, bus_req}, 0);
    step();
    chk("f_bus_req_c1", {31'd0, bus_req}, 1);
    chk("f_bus_addr", bus_addr, 32'h100);
    chk("f_bus_we", {31'd0, bus_we}, 0);
    chk("f_stall_c1", {31'd0, stall_if}, 1);
    bus_ready = 1'b1; bus_rdata = 32'h2402000A;
    sb.push_back('{is_mem: 1'b0, data: 32'h2402000A});
    step();
    chk("f_ack_c2", {31'd0, if_ack}, 1);
    chk("f_stall_c2", {31'd0, stall_if}, 0);
    chk("f_bus_req_c2", {31'd0, bus_req}, 0);
    bus_ready = 1'b0; if_req = 1'b0;
    step();

    // ready in IDLE is ignored
    bus_ready = 1'b1;
    step();
    chk("idle_ready_bus_req", {31'd0, bus_req}, 0);
    bus_ready = 1'b0;
    step();

    // simultaneous IF and MEM load: MEM first
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000;
    #1 chk("sim_stall_mem_c0", {31'd0, stall_mem}, 1);
    step();
    chk("sim_bus_addr_mem", bus_addr, 32'h2000);
    chk("sim_bus_we_mem", {31'd0, bus_we}, 0);
    bus_ready = 1'b1; bus_rdata = 32'h11112222;
    sb.push_back('{is_mem: 1'b1, data: 32'h11112222});
    step();
    chk("sim_mem_ack", {31'd0, mem_ack}, 1);
    chk("sim_stall_mem_ack", {31'd0, stall_mem}, 0);
    chk("sim_stall_if_held", {31'd0, stall_if}, 1);
    bus_ready = 1'b0; mem_req = 1'b0;
    step();
    chk("sim_idle_bus_req", {31'd0, bus_req}, 0);
    chk("sim_idle_stall_if", {31'd0, stall_if}, 1);
    step();
    chk("sim_bus_addr_if", bus_addr, 32'h104);
    bus_ready = 1'b1; bus_rdata = 32'h33334444;
    sb.push_back('{is_mem: 1'b0, data: 32'h33334444});
    step();
    chk("sim_if_ack", {31'd0, if_ack}, 1);
    bus_ready = 1'b0; if_req = 1'b0;
    step();

    // store with ready delayed 4 cycles; requester inputs change after grant
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h2004; mem_wdata = 32'hDEADBEEF;
    step();
    mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'h0; mem_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("st_bus_req", {31'd0, bus_req}, 1);
      chk("st_bus_addr", bus_addr, 32'h2004);
      chk("st_bus_we", {31'd0, bus_we}, 1);
      chk("st_bus_wdata", bus_wdata, 32'hDEADBEEF);
      chk("st_no_ack", {31'd0, mem_ack}, 0);
      if (i == 4) begin
        bus_ready = 1'b1; bus_rdata = 32'hBAD0BAD0;
        sb.push_back('{is_mem: 1'b1, data: 32'h11112222});
      end
      step();
    end
    chk("st_mem_ack", {31'd0, mem_ack}, 1);
    bus_ready = 1'b0; mem_req = 1'b0;
    step();

    // fetch killed one cycle after grant
    if_req = 1'b1; if_addr = 32'h180;
    step();
    chk("k_bus_req", {31'd0, bus_req}, 1);
    if_kill = 1'b1;
    step();
    if_kill = 1'b0; if_req = 1'b0;
    bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
    step();
    chk("k_no_ack", {31'd0, if_ack}, 0);
    chk("k_bus_req_resp", {31'd0, bus_req}, 0);
    bus_ready = 1'b0;
    step();
    chk("k_idle_bus_req", {31'd0, bus_req}, 0);
    if_req = 1'b1; if_addr = 32'h200;
    step();
    chk("k_new_addr", bus_addr, 32'h200);
    bus_ready = 1'b1; bus_rdata = 32'h8C220004;
    sb.push_back('{is_mem: 1'b0, data: 32'h8C220004});
    step();
    chk("k_new_ack", {31'd0, if_ack}, 1);
    bus_ready = 1'b0; if_req = 1'b0;
    step();

    // asynchronous reset in BUS_MEM, held request re-granted afterwards
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000;
    step();
    step();
    chk("r_bus_req_before", {31'd0, bus_req}, 1);
    rst_n = 1'b0;
    #1;
    chk("r_bus_req", {31'd0, bus_req}, 0);
    chk("r_bus_addr", bus_addr, 0);
    chk("r_mem_rdata", mem_rdata, 0);
    chk("r_if_rdata", if_rdata, 0);
    chk("r_stall_mem", {31'd0, stall_mem}, 1);
    step();
    rst_n = 1'b1;
    #1 chk("r_idle_bus_req", {31'd0, bus_req}, 0);
    step();
    chk("r_regrant_req", {31'd0, bus_req}, 1);
    chk("r_regrant_addr", bus_addr, 32'h3000);
    bus_ready = 1'b1; bus_rdata = 32'h55AA55AA;
    sb.push_back('{is_mem: 1'b1, data: 32'h55AA55AA});
    step();
    chk("r_mem_ack", {31'd0, mem_ack}, 1);
    chk("r_bus_err", {31'd0, bus_err}, 0);
    bus_ready = 1'b0; mem_req = 1'b0;
    step();

`ifdef ARB_TIMEOUT_EN
    // ready never arrives: bus_req for 15 cycles then error response
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000;
    step();
    for (int i = 1; i <= 15; i++) begin
      chk("to_bus_req", {31'd0, bus_req}, 1);
      chk("to_no_err", {31'd0, bus_err}, 0);
      if (i == 15) sb.push_back('{is_mem: 1'b1, data: 32'h0});
      step();
    end
    chk("to_bus_req_drop", {31'd0, bus_req}, 0);
    chk("to_bus_err", {31'd0, bus_err}, 1);
    chk("to_mem_ack", {31'd0, mem_ack}, 1);
    mem_req = 1'b0;
    step();
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
